spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync.sv | 37 +++
 rtl/spi_slave.sv | 189 ++++++++++++++++++
 tb/tb_spi_slave.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, synchronizer depth and idle transmit pattern
// for the SPI mode-0 slave and its helpers.
package spi_pkg;

  // Frame width in bits; the slave only supports byte frames.
  localparam int SPI_DATA_W      = 8;

  // Depth of each input synchronizer chain.
  localparam int SPI_SYNC_STAGES = 2;

  // Pattern shifted out when a byte starts with nothing buffered.
  localparam logic [SPI_DATA_W-1:0] SPI_IDLE_TX = 8'hFF;

  // Width of the in-frame bit counter (wraps naturally after a full byte).
  localparam int SPI_CNT_W = $clog2(SPI_DATA_W);

  typedef logic [SPI_DATA_W-1:0] spi_byte_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-stage flop chain bringing one asynchronous bit into the
// clk domain. Reset value is a parameter so idle-high lines (chip select)
// come out of reset in their inactive state.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage samples the raw asynchronous input.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= RST_VAL;
          else        sync_reg[gi] <= d;
        end
      end else begin : g_next
        // Later stages resolve metastability from the previous stage.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= RST_VAL;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0), MSB-first byte slave clocked by an
// oversampling system clock. SCK/CS/MOSI are synchronized, SCK edges are found
// against a registered copy, received bytes are presented with a one-cycle
// valid pulse, and a single-entry tx buffer feeds the MISO shift register at
// each byte start (CS fall, or the SCK fall that follows a completed byte).
module spi_slave
  import spi_pkg::*;
(
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_spi_sck,
  input  logic                  I_spi_cs,
  input  logic                  I_spi_mosi,
  output logic                  O_spi_miso,
  input  logic [SPI_DATA_W-1:0] I_tx_data,
  input  logic                  I_tx_load,
  output logic                  O_tx_ready,
  output logic [SPI_DATA_W-1:0] O_rx_data,
  output logic                  O_rx_valid,
  output logic                  O_tx_underrun,
  output logic                  O_busy
);

  localparam int SETTLE_W = $clog2(SPI_SYNC_STAGES + 1);

  // Synchronized inputs and edge-detect history.
  logic                  sck_sync;
  logic                  cs_sync;
  logic                  mosi_sync;
  logic                  sck_prev_reg;
  logic                  cs_prev_reg;

  // Post-reset arming: bits are only accepted after CS has been seen high
  // with fully flushed synchronizers, so a transfer interrupted by reset is
  // never resumed half way through.
  logic [SETTLE_W-1:0]   settle_cnt_reg;
  logic                  armed_reg;

  // Receive path state.
  spi_byte_t             rx_shift_reg;
  spi_byte_t             rx_data_reg;
  logic [SPI_CNT_W-1:0]  bit_cnt_reg;
  logic                  rx_valid_reg;
  logic                  byte_done_reg;

  // Transmit path state.
  spi_byte_t             tx_shift_reg;
  spi_byte_t             tx_buf_reg;
  logic                  buf_full_reg;
  logic                  underrun_reg;

  // Decoded events for the current cycle.
  logic                  settled;
  logic                  active;
  logic                  sck_rise;
  logic                  sck_fall;
  logic                  cs_fall;
  logic                  byte_start;
  logic                  tx_shift_en;
  logic                  last_bit;
  logic                  load_ok;

  spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .d     (I_spi_sck),
    .q     (sck_sync)
  );

  spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .d     (I_spi_cs),
    .q     (cs_sync)
  );

  spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .d     (I_spi_mosi),
    .q     (mosi_sync)
  );

  assign settled     = (settle_cnt_reg == SETTLE_W'(SPI_SYNC_STAGES));
  // A CS-high cycle is handled as "not active", so CS deassertion always
  // beats an SCK edge that is detected in the same cycle.
  assign active      = armed_reg & ~cs_sync;
  assign sck_rise    = active &  sck_sync & ~sck_prev_reg;
  assign sck_fall    = active & ~sck_sync &  sck_prev_reg;
  assign cs_fall     = armed_reg & cs_prev_reg & ~cs_sync;
  assign byte_start  = cs_fall | (sck_fall & byte_done_reg);
  assign tx_shift_en = sck_fall & ~byte_done_reg;
  assign last_bit    = (bit_cnt_reg == SPI_CNT_W'(SPI_DATA_W - 1));
  // A load coinciding with a byte start lands in the buffer just emptied.
  assign load_ok     = I_tx_load & (~buf_full_reg | byte_start);

  // Edge history, synchronizer flush counter and post-reset arming.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sck_prev_reg   <= 1'b0;
      cs_prev_reg    <= 1'b1;
      settle_cnt_reg <= '0;
      armed_reg      <= 1'b0;
    end else begin
      sck_prev_reg <= sck_sync;
      cs_prev_reg  <= cs_sync;
      if (!settled) begin
        settle_cnt_reg <= settle_cnt_reg + SETTLE_W'(1);
      end
      if (settled && cs_sync) begin
        armed_reg <= 1'b1;
      end
    end
  end

  // Receive: shift MOSI on SCK rise, publish each completed byte.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rx_shift_reg  <= '0;
      rx_data_reg   <= '0;
      bit_cnt_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      byte_done_reg <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (!active) begin
        // Deselected: drop any partial byte, keep the shift register.
        bit_cnt_reg   <= '0;
        byte_done_reg <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_shift_reg <= {rx_shift_reg[SPI_DATA_W-2:0], mosi_sync};
          bit_cnt_reg  <= bit_cnt_reg + SPI_CNT_W'(1);
          if (last_bit) begin
            rx_data_reg   <= {rx_shift_reg[SPI_DATA_W-2:0], mosi_sync};
            rx_valid_reg  <= 1'b1;
            byte_done_reg <= 1'b1;
          end
        end
        if (byte_start) begin
          byte_done_reg <= 1'b0;
        end
      end
    end
  end

  // Transmit shifter: reload at byte start, advance on mid-byte SCK fall.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      tx_shift_reg <= '0;
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;
      if (byte_start) begin
        if (buf_full_reg) begin
          tx_shift_reg <= tx_buf_reg;
        end else begin
          tx_shift_reg <= SPI_IDLE_TX;
          underrun_reg <= 1'b1;
        end
      end else if (tx_shift_en) begin
        tx_shift_reg <= {tx_shift_reg[SPI_DATA_W-2:0], 1'b0};
      end
    end
  end

  // Single-entry tx buffer: filled by accepted loads, emptied at byte start.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      tx_buf_reg   <= '0;
      buf_full_reg <= 1'b0;
    end else begin
      if (load_ok) begin
        tx_buf_reg   <= I_tx_data;
        buf_full_reg <= 1'b1;
      end else if (byte_start) begin
        buf_full_reg <= 1'b0;
      end
    end
  end

  assign O_spi_miso    = active & tx_shift_reg[SPI_DATA_W-1];
  assign O_tx_ready    = ~buf_full_reg;
  assign O_rx_data     = rx_data_reg;
  assign O_rx_valid    = rx_valid_reg;
  assign O_tx_underrun = underrun_reg;
  assign O_busy        = ~cs_sync;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives SPI mode-0 transfers at clk/16 and compares the slave
// against a transaction-level model: a one-entry tx buffer consumed at every
// byte start (CS fall and each SCK fall after a full byte), 0xFF on empty.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic       miso;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       underrun;
  logic       busy;

  always #5 clk = ~clk;

  spi_slave dut (
    .I_clk         (clk),
    .I_rst_n       (rst_n),
    .I_spi_sck     (sck),
    .I_spi_cs      (cs),
    .I_spi_mosi    (mosi),
    .O_spi_miso    (miso),
    .I_tx_data     (tx_data),
    .I_tx_load     (tx_load),
    .O_tx_ready    (tx_ready),
    .O_rx_data     (rx_data),
    .O_rx_valid    (rx_valid),
    .O_tx_underrun (underrun),
    .O_busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling clock edge.
  int         cyc = 0;
  int         valid_cyc = 0;
  int         under_seen = 0;
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_q.push_back(rx_data);
      valid_cyc = cyc;
    end
    if (underrun === 1'b1) under_seen++;
  end

  // Reference model of the tx buffer.
  bit         m_full = 1'b0;
  logic [7:0] m_buf = 8'h00;
  int         m_under = 0;

  function automatic void model_load(input logic [7:0] v);
    if (!m_full) begin
      m_full = 1'b1;
      m_buf  = v;
    end
  endfunction

  function automatic logic [7:0] model_start();
    if (m_full) begin
      m_full = 1'b0;
      return m_buf;
    end
    m_under++;
    return 8'hFF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    model_load(v);
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Master sends nbits of mo MSB first; optional load mid-byte.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit do_ld,
                      input logic [7:0] ldv, output logic [7:0] mi,
                      output int rise_cyc, output int u_at_rise);
    mi = 8'h00;
    rise_cyc = 0;
    u_at_rise = 0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      tick(8);
      mi = {mi[6:0], miso};
      sck = 1'b1;
      rise_cyc = cyc;
      u_at_rise = under_seen;
      if (do_ld && i == 3) begin
        tick(3);
        pulse_load(ldv);
        tick(4);
      end else begin
        tick(8);
      end
      sck = 1'b0;
    end
    tick(8);
  endtask

  logic [7:0] w_mo[4];
  bit         w_ld[4];
  logic [7:0] w_lv[4];

  // One CS-low window of nb full bytes; collide loads cv on the CS-fall start.
  task automatic window(input int nb, input bit collide, input logic [7:0] cv);
    logic [7:0] exp_mi;
    logic [7:0] got_mi;
    int         rc;
    int         um;
    int         lat;
    cs = 1'b0;
    exp_mi = model_start();
    tick(2);
    if (collide) pulse_load(cv);
    else         tick(1);
    tick(2);
    check("busy", busy, 1);
    for (int b = 0; b < nb; b++) begin
      xfer(w_mo[b], 8, w_ld[b], w_lv[b], got_mi, rc, um);
      $display("byte %0d: mosi %02h miso %02h (exp %02h)", b, w_mo[b], got_mi, exp_mi);
      check("miso_byte", got_mi, exp_mi);
      check("underrun_mid", um, m_under);
      exp_mi = model_start();
      check("rx_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("rx_data", rx_q.pop_front(), w_mo[b]);
      lat = valid_cyc - rc;
      check("rx_latency", (lat >= 3 && lat <= 5), 1);
      check("tx_ready", tx_ready, !m_full);
      rx_q.delete();
    end
    cs = 1'b1;
    tick(8);
    check("underrun_total", under_seen, m_under);
    check("busy_idle", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_rx_data"}, rx_data, 8'h00);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
  endtask

  task automatic set_bytes(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 4; i++) begin
      w_ld[i] = 1'b0;
      w_lv[i] = 8'h00;
    end
    w_mo[0] = a;
    w_mo[1] = b;
  endtask

  initial begin
    logic [7:0] gm;
    int         rc;
    int         um;

    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(6);

    // Single byte with a preloaded response; second load ignored (buffer full).
    pulse_load(8'hA5);
    check("tx_ready_loaded", tx_ready, 0);
    pulse_load(8'hEE);
    tick(4);
    set_bytes(8'h3C, 8'h00);
    window(1, 1'b0, 8'h00);

    // Back-to-back bytes, second response loaded during the first byte.
    pulse_load(8'h12);
    tick(4);
    set_bytes(8'hF0, 8'h0F);
    w_ld[0] = 1'b1;
    w_lv[0] = 8'h34;
    window(2, 1'b0, 8'h00);

    // Underrun: nothing loaded.
    set_bytes(8'h96, 8'h00);
    window(1, 1'b0, 8'h00);

    // Abort after 5 bits: no rx byte, consumed tx byte lost.
    pulse_load(8'h77);
    tick(4);
    cs = 1'b0;
    gm = model_start();
    tick(5);
    xfer(8'hC3, 5, 1'b0, 8'h00, gm, rc, um);
    cs = 1'b1;
    tick(8);
    check("abort_no_rx", rx_q.size(), 0);
    set_bytes(8'h81, 8'h00);
    window(1, 1'b0, 8'h00);

    // Reset after 3 bits, then bits with CS still low must be ignored.
    pulse_load(8'h66);
    tick(4);
    cs = 1'b0;
    gm = model_start();
    tick(3);
    pulse_load(8'h99);
    tick(1);
    xfer(8'hE7, 3, 1'b0, 8'h00, gm, rc, um);
    check("pre_reset_tx_ready", tx_ready, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_full = 1'b0;
    rx_q.delete();
    tick(3);
    rst_n = 1'b1;
    xfer(8'hFF, 8, 1'b0, 8'h00, gm, rc, um);
    check("post_reset_ignored_rx", rx_q.size(), 0);
    check("post_reset_ignored_miso", gm, 8'h00);
    cs = 1'b1;
    tick(8);
    set_bytes(8'h5A, 8'h00);
    window(1, 1'b0, 8'h00);

    // Load collision on the CS-fall byte start: consume-then-fill.
    pulse_load(8'hC3);
    tick(4);
    set_bytes(8'h11, 8'h22);
    window(2, 1'b1, 8'h7E);

    // Randomized windows.
    for (int t = 0; t < 30; t++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        w_mo[i] = 8'($urandom);
        w_ld[i] = 1'($urandom);
        w_lv[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) pulse_load(8'($urandom));
      if ($urandom_range(0, 3) == 0) pulse_load(8'($urandom));
      tick($urandom_range(2, 6));
      window(nb, ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
